// File: rtl/fnd_scan_display_gen_if.sv
// Bus bundle for the FND scan/display controller: load port, decimal-point
// mask, ASCII TX stream and the board-level digit/segment pins.
interface fnd_scan_display_gen_if #(
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 14
);
  logic [DATA_W-1:0]   i_data;
  logic                i_valid;
  logic [N_DIGITS-1:0] i_dp_mask;
  logic                i_tx_start;
  logic                i_tx_ready;
  logic [7:0]          o_tx_data;
  logic                o_tx_valid;
  logic                o_busy;
  logic [N_DIGITS-1:0] fnd_com;
  logic [7:0]          fnd_data;

  modport master (
    output i_data, i_valid, i_dp_mask, i_tx_start, i_tx_ready,
    input  o_tx_data, o_tx_valid, o_busy, fnd_com, fnd_data
  );

  modport slave (
    input  i_data, i_valid, i_dp_mask, i_tx_start, i_tx_ready,
    output o_tx_data, o_tx_valid, o_busy, fnd_com, fnd_data
  );
endinterface

// File: rtl/fnd_scan_display_gen.sv
// N-digit multiplexed 7-segment controller: sequential double-dabble
// binary-to-BCD, leading-zero blanking, per-digit decimal points and an
// ASCII byte stream (valid/ready) of the displayed value.
module fnd_scan_display_gen #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 14,
  parameter int BLANK_LZ = 1
) (
  input logic clk,
  input logic rst,
  fnd_scan_display_gen_if.slave bus
);

  localparam int TICK_DIV = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = $clog2(N_DIGITS);
  // Enough BCD digits to hold 2^DATA_W-1, so overflow is seen as a nonzero
  // digit above the displayed ones.
  localparam int BCD_NEED = (DATA_W * 31) / 100 + 1;
  localparam int BCD_D    = (BCD_NEED > N_DIGITS) ? BCD_NEED : N_DIGITS;
  localparam int SH_W     = $clog2(DATA_W + 1);
  localparam int TXI_W    = $clog2(N_DIGITS + 2);

  localparam logic [1:0] CV_IDLE  = 2'd0;
  localparam logic [1:0] CV_SHIFT = 2'd1;
  localparam logic [1:0] CV_DONE  = 2'd2;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

  // Scan timing
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  tick;
  logic [IDX_W-1:0]      idx_q, idx_d;

  // Converter
  logic [1:0]            cv_state_q, cv_state_d;
  logic [DATA_W-1:0]     bin_q, bin_d;
  logic [BCD_D*4-1:0]    work_q, work_d;
  logic [BCD_D*4-1:0]    adj;
  logic                  ovf_calc;
  logic [SH_W-1:0]       sh_cnt_q, sh_cnt_d;
  logic [N_DIGITS*4-1:0] disp_bcd_q, disp_bcd_d;
  logic                  ovf_q, ovf_d;

  // Scan output
  logic [IDX_W-1:0]      lit_top;
  logic [3:0]            cur_digit;
  logic [7:0]            scan_seg;
  logic [N_DIGITS-1:0]   fnd_com_q, fnd_com_d;
  logic [7:0]            fnd_data_q, fnd_data_d;

  // TX stream
  logic [0:0]            tx_state_q, tx_state_d;
  logic [TXI_W-1:0]      tx_idx_q, tx_idx_d;
  logic [N_DIGITS*4-1:0] tx_bcd_q, tx_bcd_d;
  logic                  tx_ovf_q, tx_ovf_d;
  logic [TXI_W-1:0]      tx_pos;
  logic [3:0]            tx_digit;
  logic [7:0]            tx_char;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Refresh tick generator and digit index rotation
  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    idx_d      = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Double-dabble converter: latch, DATA_W add-3/shift steps, commit
  always_comb begin
    adj = work_q;
    for (int unsigned i = 0; i < BCD_D; i++) begin
      if (work_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
      end
    end
    ovf_calc = 1'b0;
    for (int unsigned i = N_DIGITS; i < BCD_D; i++) begin
      ovf_calc = ovf_calc | (work_q[i*4 +: 4] != 4'd0);
    end

    cv_state_d = cv_state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    sh_cnt_d   = sh_cnt_q;
    disp_bcd_d = disp_bcd_q;
    ovf_d      = ovf_q;

    case (cv_state_q)
      CV_IDLE: begin
        if (bus.i_valid) begin
          bin_d      = bus.i_data;
          work_d     = '0;
          sh_cnt_d   = '0;
          cv_state_d = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        work_d   = {adj[BCD_D*4-2:0], bin_q[DATA_W-1]};
        bin_d    = {bin_q[DATA_W-2:0], 1'b0};
        sh_cnt_d = sh_cnt_q + SH_W'(1);
        if (sh_cnt_q == SH_W'(DATA_W - 1)) begin
          cv_state_d = CV_DONE;
        end
      end
      CV_DONE: begin
        disp_bcd_d = work_q[N_DIGITS*4-1:0];
        ovf_d      = ovf_calc;
        cv_state_d = CV_IDLE;
      end
      default: cv_state_d = CV_IDLE;
    endcase
  end

  // Segment pattern for the current digit, registered on each tick
  always_comb begin
    lit_top = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (disp_bcd_q[k*4 +: 4] != 4'd0 || bus.i_dp_mask[k]) begin
        lit_top = IDX_W'(k);
      end
    end
    cur_digit = disp_bcd_q[idx_q*4 +: 4];
    scan_seg  = seg7(cur_digit);
    if (bus.i_dp_mask[idx_q]) begin
      scan_seg[7] = 1'b0;
    end
    // Digit 0 can never exceed lit_top, so it is never blanked.
    if (BLANK_LZ != 0 && idx_q > lit_top) begin
      scan_seg = 8'hFF;
    end
    if (ovf_q) begin
      scan_seg = 8'hBF;
    end

    fnd_com_d  = fnd_com_q;
    fnd_data_d = fnd_data_q;
    if (tick) begin
      fnd_com_d  = ~(N_DIGITS'(1) << idx_q);
      fnd_data_d = scan_seg;
    end
  end

  // ASCII stream: snapshot on start, MSD first, then CR LF
  always_comb begin
    tx_pos   = TXI_W'(N_DIGITS - 1) - tx_idx_q;
    tx_digit = '0;
    if (tx_idx_q < TXI_W'(N_DIGITS)) begin
      tx_digit = tx_bcd_q[tx_pos*4 +: 4];
    end
    if (tx_idx_q < TXI_W'(N_DIGITS)) begin
      tx_char = tx_ovf_q ? 8'h2D : (8'h30 + {4'h0, tx_digit});
    end else if (tx_idx_q == TXI_W'(N_DIGITS)) begin
      tx_char = 8'h0D;
    end else begin
      tx_char = 8'h0A;
    end

    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_bcd_d   = tx_bcd_q;
    tx_ovf_d   = tx_ovf_q;

    case (tx_state_q)
      TX_IDLE: begin
        if (bus.i_tx_start) begin
          tx_bcd_d   = disp_bcd_q;
          tx_ovf_d   = ovf_q;
          tx_idx_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (bus.i_tx_ready) begin
          if (tx_idx_q == TXI_W'(N_DIGITS + 1)) begin
            tx_idx_d   = '0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + TXI_W'(1);
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // All state registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      idx_q      <= '0;
      cv_state_q <= CV_IDLE;
      bin_q      <= '0;
      work_q     <= '0;
      sh_cnt_q   <= '0;
      disp_bcd_q <= '0;
      ovf_q      <= 1'b0;
      fnd_com_q  <= '1;
      fnd_data_q <= 8'hFF;
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_bcd_q   <= '0;
      tx_ovf_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      cv_state_q <= cv_state_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      sh_cnt_q   <= sh_cnt_d;
      disp_bcd_q <= disp_bcd_d;
      ovf_q      <= ovf_d;
      fnd_com_q  <= fnd_com_d;
      fnd_data_q <= fnd_data_d;
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_bcd_q   <= tx_bcd_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  assign bus.o_busy     = (cv_state_q != CV_IDLE);
  assign bus.o_tx_valid = (tx_state_q == TX_SEND);
  assign bus.o_tx_data  = (tx_state_q == TX_SEND) ? tx_char : 8'h00;
  assign bus.fnd_com    = fnd_com_q;
  assign bus.fnd_data   = fnd_data_q;

endmodule

// File: tb/tb_fnd_scan_display_gen.sv
// Scoreboard bench for fnd_scan_display_gen (4 digits, 14-bit input,
// tick every 10 clocks). Stimulus pushes expected scan frames, TX bytes and
// busy lengths; independent monitors pop and compare.
module tb_fnd_scan_display_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fnd_scan_display_gen_if #(.N_DIGITS(4), .DATA_W(14)) bus ();

  fnd_scan_display_gen #(
    .CLK_HZ(1000), .SCAN_HZ(100), .N_DIGITS(4), .DATA_W(14), .BLANK_LZ(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] frame_q[$];   // {digit3, digit2, digit1, digit0}
  logic [7:0]  tx_q[$];
  int          busy_q[$];
  logic [3:0]  seen_mask = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scan monitor: each digit update is compared against the pending frame
  logic [3:0] prev_com = 4'hF;
  always @(negedge clk) begin
    int k;
    logic [3:0]  pat;
    logic [31:0] f;
    if (!rst && bus.fnd_com !== prev_com && bus.fnd_com !== 4'hF && frame_q.size() > 0) begin
      k = -1;
      for (int i = 0; i < 4; i++) begin
        pat = 4'b0001 << i;
        if (bus.fnd_com === ~pat) k = i;
      end
      if (k < 0) begin
        chk("fnd_com_onehot", {28'h0, bus.fnd_com}, 32'h0000000E);
      end else begin
        f = frame_q[0];
        chk($sformatf("digit%0d", k), {24'h0, bus.fnd_data}, {24'h0, f[k*8 +: 8]});
        seen_mask[k] = 1'b1;
        if (seen_mask == 4'hF) begin
          void'(frame_q.pop_front());
          seen_mask = 4'h0;
        end
      end
    end
    prev_com = bus.fnd_com;
  end

  // TX monitor: byte order on transfer, and data hold while stalled
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("tx_hold", {24'h0, bus.o_tx_data}, {24'h0, prev_data});
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (tx_q.size() == 0) begin
          chk("tx_extra", {24'h0, bus.o_tx_data}, 32'hFFFFFFFF);
        end else begin
          chk("tx_byte", {24'h0, bus.o_tx_data}, {24'h0, tx_q.pop_front()});
        end
      end
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data  = bus.o_tx_data;
    end
  end

  // Busy monitor: length of each busy pulse
  int bcount = 0;
  always @(negedge clk) begin
    if (rst) begin
      bcount = 0;
    end else if (bus.o_busy) begin
      bcount++;
    end else if (bcount > 0) begin
      if (busy_q.size() == 0) chk("busy_extra", bcount, 0);
      else chk("busy_len", bcount, busy_q.pop_front());
      bcount = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int v, input bit expect_done);
    bus.i_data  = 14'(v);
    bus.i_valid = 1'b1;
    if (expect_done) busy_q.push_back(15);
    cyc(1);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (bus.o_busy && n < 60) begin
      cyc(1);
      n++;
    end
    chk("busy_timeout", {31'h0, bus.o_busy}, 0);
  endtask

  task automatic wait_frames();
    int n = 0;
    while (frame_q.size() != 0 && n < 300) begin
      cyc(1);
      n++;
    end
    chk("frame_timeout", frame_q.size(), 0);
    frame_q.delete();
    seen_mask = 4'h0;
  endtask

  task automatic wait_tx();
    int n = 0;
    while (tx_q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("tx_timeout", tx_q.size(), 0);
    tx_q.delete();
  endtask

  task automatic tx_start_pulse();
    bus.i_tx_start = 1'b1;
    cyc(1);
    bus.i_tx_start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_com"},  {28'h0, bus.fnd_com}, 32'h0000000F);
    chk({tag, "_seg"},  {24'h0, bus.fnd_data}, 32'h000000FF);
    chk({tag, "_txv"},  {31'h0, bus.o_tx_valid}, 0);
    chk({tag, "_txd"},  {24'h0, bus.o_tx_data}, 0);
    chk({tag, "_busy"}, {31'h0, bus.o_busy}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.i_data     = '0;
    bus.i_valid    = 1'b0;
    bus.i_dp_mask  = '0;
    bus.i_tx_start = 1'b0;
    bus.i_tx_ready = 1'b0;
    cyc(3);
    rst = 1'b0;

    // Blank until the first tick, then digit 0 shows '0'
    cyc(3);
    chk_reset_outputs("rst_init");
    frame_q.push_back(32'hFFFFFFC0);
    wait_frames();

    // 1234, with a second load during conversion that must be ignored
    load(1234, 1'b1);
    cyc(1);
    bus.i_data  = 14'd9;
    bus.i_valid = 1'b1;
    cyc(1);
    bus.i_valid = 1'b0;
    wait_busy_low();
    cyc(2);
    frame_q.push_back(32'hF9A4B099);
    wait_frames();

    // 7 with dp on digit 2 extends the lit range
    bus.i_dp_mask = 4'b0100;
    load(7, 1'b1);
    wait_busy_low();
    cyc(2);
    frame_q.push_back(32'hFF40C0F8);
    wait_frames();

    // Overflow: dashes everywhere, dp ignored; stream of dashes
    bus.i_dp_mask = 4'b0011;
    load(10000, 1'b1);
    wait_busy_low();
    cyc(2);
    frame_q.push_back(32'hBFBFBFBF);
    wait_frames();
    bus.i_dp_mask  = 4'b0000;
    bus.i_tx_ready = 1'b1;
    tx_q.push_back(8'h2D); tx_q.push_back(8'h2D); tx_q.push_back(8'h2D);
    tx_q.push_back(8'h2D); tx_q.push_back(8'h0D); tx_q.push_back(8'h0A);
    tx_start_pulse();
    wait_tx();
    cyc(2);
    chk("txv_after_ovf", {31'h0, bus.o_tx_valid}, 0);

    // 42 streamed with back-pressure; restart and reload mid-stream ignored
    load(42, 1'b1);
    wait_busy_low();
    cyc(2);
    frame_q.push_back(32'hFFFF99A4);
    wait_frames();
    bus.i_tx_ready = 1'b0;
    tx_q.push_back(8'h30); tx_q.push_back(8'h30); tx_q.push_back(8'h34);
    tx_q.push_back(8'h32); tx_q.push_back(8'h0D); tx_q.push_back(8'h0A);
    tx_start_pulse();
    for (int c = 0; c < 150; c++) begin
      bus.i_tx_ready = ((c % 4) == 3);
      bus.i_tx_start = (c == 5);
      bus.i_valid    = (c == 8);
      bus.i_data     = 14'd5;
      if (c == 8) busy_q.push_back(15);
      if (tx_q.size() == 0 && c > 12) break;
      cyc(1);
    end
    bus.i_tx_ready = 1'b0;
    bus.i_tx_start = 1'b0;
    bus.i_valid    = 1'b0;
    chk("tx42_drained", tx_q.size(), 0);
    tx_q.delete();
    cyc(2);
    chk("txv_after_lf", {31'h0, bus.o_tx_valid}, 0);
    wait_busy_low();
    cyc(2);
    frame_q.push_back(32'hFFFFFF92);
    wait_frames();

    // Reset during conversion
    load(999, 1'b0);
    cyc(4);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_shift");
    cyc(2);
    rst = 1'b0;
    frame_q.push_back(32'hFFFFFFC0);
    wait_frames();

    // Reset during a stream: partial stream dropped, display back to zero
    load(42, 1'b1);
    wait_busy_low();
    cyc(2);
    bus.i_tx_ready = 1'b0;
    tx_start_pulse();
    cyc(2);
    chk("txv_in_send", {31'h0, bus.o_tx_valid}, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_send");
    cyc(2);
    rst = 1'b0;
    bus.i_tx_ready = 1'b1;
    cyc(10);
    chk("txv_after_rst", {31'h0, bus.o_tx_valid}, 0);
    tx_q.push_back(8'h30); tx_q.push_back(8'h30); tx_q.push_back(8'h30);
    tx_q.push_back(8'h30); tx_q.push_back(8'h0D); tx_q.push_back(8'h0A);
    tx_start_pulse();
    wait_tx();
    frame_q.push_back(32'hFFFFFFC0);
    wait_frames();

    cyc(2);
    chk("busy_pending", busy_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
